muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle controller for RV32M multiply/divide operations, sitting beside the single-cycle ALU in the execute stage. It accepts one M-extension operation at a time and sequences it. Multiplies use a fixed, configurable latency. Divides and remainders run on an iterative radix-2 restoring divider, with early-out for the special cases. While busy it drives a stall to the hazard unit and returns a registered result with a one-cycle valid pulse.

## Interface
- `DATA_WIDTH`, default 32: operand/result width. The divider iteration count equals `DATA_WIDTH`.
- `MUL_LATENCY`, default 2: cycles from acceptance to `Valid_o` for MUL-class ops. Minimum 1.
- `clk_i`, in, 1: single clock, rising edge.
- `rst_n_i`, in, 1: synchronous, active-low reset.
- `Start_i`, in, 1: request valid; sampled only when `Ready_o`=1.
- `Op_i`, in, 3: funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `SrcA_i`, in, `DATA_WIDTH`: rs1 value (multiplicand/dividend).
- `SrcB_i`, in, `DATA_WIDTH`: rs2 value (multiplier/divisor).
- `Flush_i`, in, 1: abort the in-flight op; no result is produced.
- `Ready_o`, out, 1: high in IDLE and DONE.
- `Busy_o`, out, 1: pipeline stall request; high in MUL, DIV_CALC and DIV_FIX.
- `Valid_o`, out, 1: one-cycle pulse while in DONE.
- `Result_o`, out, `DATA_WIDTH`: registered result, held until the next result is written.
- `Error_o`, out, 1: qualifies `Valid_o`; set only for divide ops when divide support is compiled out.

## Operation
- States: IDLE, MUL, DIV_CALC, DIV_FIX, DONE.
- Acceptance happens when `Start_i` is high, `Ready_o` is high and `Flush_i` is low. Operands and op are captured at acceptance; later input changes are ignored.
- IDLE/DONE to MUL for ops 0–3. A cycle counter loads `MUL_LATENCY`-1. When `MUL_LATENCY`=1 the FSM goes straight to DONE.
- Multiply result select: MUL takes the low half of the unsigned product. MULH takes the high half of signed×signed. MULHSU takes the high half of signed×unsigned. MULHU takes the high half of unsigned×unsigned. All products are 2×`DATA_WIDTH` wide.
- IDLE/DONE for ops 4–7 branches three ways:
  - Divisor zero: go to DONE. Quotient is all-ones. Remainder is the dividend.
  - Signed overflow (DIV/REM with dividend = most-negative value and divisor = -1): go to DONE. Quotient is the most-negative value. Remainder is 0.
  - Otherwise: go to DIV_CALC with absolute values for signed ops and unsigned values for DIVU/REMU. Record the quotient sign (signA XOR signB) and the remainder sign (signA).
- DIV_CALC runs exactly `DATA_WIDTH` iterations of shift-subtract-restore, tracked by an iteration counter, then goes to DIV_FIX.
- DIV_FIX applies two's-complement negation per the recorded signs and selects quotient (DIV/DIVU) or remainder (REM/REMU) into `Result_o`, then goes to DONE.
- DONE asserts `Valid_o` for one cycle. It goes to IDLE if no new acceptance occurs that cycle; a new acceptance in DONE starts the next op directly (back-to-back ops).
- Requests outside IDLE/DONE are ignored; no queueing.
- `Flush_i` in any state forces IDLE on the next edge. It overrides a same-cycle `Start_i`, and `Result_o` is not updated.
- `Busy_o` is combinational from state only, never from inputs.

## Timing
- Reset values: state IDLE, `Ready_o`=1, `Busy_o`=0, `Valid_o`=0, `Result_o`=0, `Error_o`=0, all counters 0.
- Acceptance occurs at edge N:
  - MUL ops: `Valid_o` in cycle N+`MUL_LATENCY`.
  - Divide special cases: `Valid_o` in cycle N+1.
  - Normal divide: DIV_CALC in cycles N+1..N+32, DIV_FIX in N+33, `Valid_o` in N+34 (at `DATA_WIDTH`=32).
- Reset asserted mid-operation returns the FSM to IDLE with reset values on the next edge, and no `Valid_o` is produced.
- Flush in cycle K: IDLE in K+1 and `Ready_o`=1 in K+1.

## Configuration
- `MULDIV_DIV_EN` defined: full divide path as described above.
- Undefined: no divider logic is instantiated. Ops 4–7 go to DONE in N+1 with `Result_o`=0, `Valid_o`=1, `Error_o`=1. MUL timing is unchanged.

## Structure
- `muldiv_pkg`:
  - `muldiv_op_e` enum, matching the funct3 encoding above.
  - `muldiv_state_e` enum.
  - Constants for the divide-by-zero quotient and the most-negative value.
- Sub-module `muldiv_div_core`: divide datapath containing the remainder/quotient registers and the one-iteration subtract/restore step. It takes load/step enables from the FSM.
- FSM, counters, sign fix-up and result select stay in `muldiv_sequencer`.

## Test plan
- MULHU 0xFFFFFFFF × 0xFFFFFFFF gives `Result_o`=0xFFFFFFFE, with `Valid_o` in N+2 and `Busy_o` high in N+1. MULH of the same operands gives 0x00000000.
- DIV −7 (0xFFFFFFF9) / 2 gives 0xFFFFFFFD at N+34. REM of the same operands gives 0xFFFFFFFF. `Busy_o` is high in N+1..N+33.
- DIVU 5 / 0 gives 0xFFFFFFFF at N+1. REM 5 / 0 gives 5. DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 at N+1. REM of the same operands gives 0.
- DIV with `Flush_i` asserted in N+10: no `Valid_o`, `Ready_o`=1 in N+11, and `Result_o` keeps its previous value. `Start_i` together with `Flush_i` in IDLE is not accepted.
- Back-to-back: MUL 3×4 accepted, then a new MUL 5×6 accepted in the DONE cycle. Expect `Valid_o` with 12, then `Valid_o` with 30, two cycles apart. `rst_n_i`=0 mid-DIV gives reset values on the next edge.
- With `MULDIV_DIV_EN` undefined: DIV 10 / 2 gives `Valid_o`=1, `Error_o`=1 and `Result_o`=0 at N+1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MUL      = 3'd1,
    ST_DIV_CALC = 3'd2,
    ST_DIV_FIX  = 3'd3,
    ST_DONE     = 3'd4
  } muldiv_state_e;

  localparam int unsigned MAX_WIDTH = 64;

  // Truncated to the datapath width at the point of use.
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  function automatic logic [MAX_WIDTH-1:0] most_negative(input int unsigned width);
    return MAX_WIDTH'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divide datapath: one shift/subtract/restore step per enabled cycle.
module muldiv_div_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int unsigned W = DATA_WIDTH;

  logic [W-1:0] quo_q;
  logic [W-1:0] rem_q;
  logic [W-1:0] dvs_q;
  logic [W:0]   rem_sh;
  logic [W:0]   diff;

  // rem_q < divisor always, so diff fits in W+1 bits and diff[W] is its sign.
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      if (diff[W]) begin
        rem_q <= rem_sh[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b0};
      end else begin
        rem_q <= diff[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b1};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer with stall, registered result and valid pulse.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  Start_i,
  input  logic [2:0]            Op_i,
  input  logic [DATA_WIDTH-1:0] SrcA_i,
  input  logic [DATA_WIDTH-1:0] SrcB_i,
  input  logic                  Flush_i,
  output logic                  Ready_o,
  output logic                  Busy_o,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Result_o,
  output logic                  Error_o
);

  localparam int unsigned W       = DATA_WIDTH;
  localparam int unsigned CNT_MAX = (DATA_WIDTH > MUL_LATENCY) ? DATA_WIDTH : MUL_LATENCY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_MUL  = ST_MUL;
  localparam logic [2:0] S_DONE = ST_DONE;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     result_d;
  logic             valid_d;
  logic             error_d;
  logic             capture;
  logic             accept;

  // Sign-extending to 2W makes one unsigned multiply serve all four variants.
  function automatic logic [W-1:0] mul_sel(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic         sa;
    logic         sb;
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    logic [2*W-1:0] prod;
    sa   = (op == OP_MULH) || (op == OP_MULHSU);
    sb   = (op == OP_MULH);
    ea   = {{W{sa & a[W-1]}}, a};
    eb   = {{W{sb & b[W-1]}}, b};
    prod = ea * eb;
    return (op == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
  endfunction

  assign accept = Start_i && Ready_o && !Flush_i;

`ifdef MULDIV_DIV_EN
  localparam logic [2:0]   S_DIV_CALC = ST_DIV_CALC;
  localparam logic [2:0]   S_DIV_FIX  = ST_DIV_FIX;
  localparam logic [W-1:0] DIV0_Q     = W'(DIV_ZERO_QUOTIENT);
  localparam logic [W-1:0] MOST_NEG   = W'(most_negative(W));

  logic         div_load, div_step;
  logic         q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic         div_signed;
  logic [W-1:0] abs_a, abs_b, quo, rem, q_fix, r_fix;

  muldiv_div_core #(.DATA_WIDTH(W)) u_div_core (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  // Magnitudes go into the divider; signs are reapplied in DIV_FIX.
  always_comb begin
    div_signed = (Op_i == OP_DIV) || (Op_i == OP_REM);
    abs_a      = (div_signed && SrcA_i[W-1]) ? (~SrcA_i + W'(1)) : SrcA_i;
    abs_b      = (div_signed && SrcB_i[W-1]) ? (~SrcB_i + W'(1)) : SrcB_i;
    q_fix      = q_neg_q ? (~quo + W'(1)) : quo;
    r_fix      = r_neg_q ? (~rem + W'(1)) : rem;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign Busy_o = (state_q == S_MUL) || (state_q == S_DIV_CALC) || (state_q == S_DIV_FIX);
`else
  assign Busy_o = (state_q == S_MUL);
`endif

  assign Ready_o = (state_q == S_IDLE) || (state_q == S_DONE);

  // Next state, counters and result write-back.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = Result_o;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    capture  = 1'b0;
`ifdef MULDIV_DIV_EN
    div_load = 1'b0;
    div_step = 1'b0;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          capture = 1'b1;
          if (!Op_i[2]) begin
            if (MUL_LATENCY == 1) begin
              state_d  = S_DONE;
              valid_d  = 1'b1;
              result_d = mul_sel(Op_i, SrcA_i, SrcB_i);
            end else begin
              state_d = S_MUL;
              cnt_d   = CNT_W'(MUL_LATENCY - 1);
            end
          end else begin
`ifdef MULDIV_DIV_EN
            if (SrcB_i == '0) begin
              state_d  = S_DONE;
              valid_d  = 1'b1;
              result_d = Op_i[1] ? SrcA_i : DIV0_Q;
            end else if (div_signed && (SrcA_i == MOST_NEG) && (SrcB_i == '1)) begin
              state_d  = S_DONE;
              valid_d  = 1'b1;
              result_d = Op_i[1] ? '0 : MOST_NEG;
            end else begin
              state_d  = S_DIV_CALC;
              cnt_d    = '0;
              div_load = 1'b1;
              q_neg_d  = div_signed && (SrcA_i[W-1] ^ SrcB_i[W-1]);
              r_neg_d  = div_signed && SrcA_i[W-1];
            end
`else
            state_d  = S_DONE;
            valid_d  = 1'b1;
            error_d  = 1'b1;
            result_d = '0;
`endif
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          valid_d  = 1'b1;
          result_d = mul_sel(op_q, a_q, b_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef MULDIV_DIV_EN
      S_DIV_CALC: begin
        div_step = 1'b1;
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = S_DIV_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV_FIX: begin
        state_d  = S_DONE;
        valid_d  = 1'b1;
        result_d = op_q[1] ? r_fix : q_fix;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Flush aborts everything, including a same-cycle acceptance.
    if (Flush_i) begin
      state_d  = S_IDLE;
      result_d = Result_o;
      valid_d  = 1'b0;
      error_d  = 1'b0;
      capture  = 1'b0;
`ifdef MULDIV_DIV_EN
      div_load = 1'b0;
      div_step = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 3'd0;
      a_q      <= '0;
      b_q      <= '0;
      Result_o <= '0;
      Valid_o  <= 1'b0;
      Error_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      Result_o <= result_d;
      Valid_o  <= valid_d;
      Error_o  <= error_d;
      if (capture) begin
        op_q <= Op_i;
        a_q  <= SrcA_i;
        b_q  <= SrcB_i;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: per-cycle check against a transaction-level model plus
// directed vectors with hand-computed results and latencies.
module tb_muldiv_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned ML = 2;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    op;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic          flush;
  logic          ready;
  logic          busy;
  logic          valid;
  logic [DW-1:0] result;
  logic          error;

  int errs   = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.DATA_WIDTH(DW), .MUL_LATENCY(ML)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .Start_i  (start),
    .Op_i     (op),
    .SrcA_i   (src_a),
    .SrcB_i   (src_b),
    .Flush_i  (flush),
    .Ready_o  (ready),
    .Busy_o   (busy),
    .Valid_o  (valid),
    .Result_o (result),
    .Error_o  (error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      MUL:    return a * b;
      MULH:   begin sp = 64'(sa) * 64'(sb);             return sp[63:32]; end
      MULHSU: begin sp = 64'(sa) * $signed({32'd0, b}); return sp[63:32]; end
      MULHU:  begin up = {32'd0, a} * {32'd0, b};       return up[63:32]; end
`ifdef MULDIV_DIV_EN
      DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!o[2]) return ML;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 1;
    if (!o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return DW + 2;
`else
    return (a == b) ? 1 : 1;
`endif
  endfunction

  int          m_pend   = 0;
  logic [31:0] m_pres   = '0;
  logic        m_perr   = 1'b0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_result = '0;
  logic        m_err    = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pend = 0; m_valid = 1'b0; m_err = 1'b0; m_result = '0;
    end else if (flush) begin
      m_pend = 0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          m_valid = 1'b1; m_result = m_pres; m_err = m_perr;
        end
      end else if (start) begin
        int          lat;
        logic [31:0] r;
        logic        e;
        lat = ref_latency(op, src_a, src_b);
        r   = ref_result(op, src_a, src_b);
`ifdef MULDIV_DIV_EN
        e   = 1'b0;
`else
        e   = op[2];
`endif
        if (lat == 1) begin
          m_valid = 1'b1; m_result = r; m_err = e;
        end else begin
          m_pend = lat - 1; m_pres = r; m_perr = e;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid",  valid,  m_valid);
      chk("model_ready",  ready,  m_pend == 0);
      chk("model_busy",   busy,   m_pend != 0);
      chk("model_error",  error,  m_err);
      chk("model_result", result, m_result);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_valid(output int lat, output logic [31:0] res, output logic err);
    lat = 1;
    while ((valid !== 1'b1) && (lat < 200)) begin
      @(negedge clk);
      lat++;
    end
    chk("valid_seen", valid, 1'b1);
    res = result;
    err = error;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input logic exp_err);
    int          lat;
    logic [31:0] res;
    logic        err;
    issue(o, a, b);
    chk({name, "_busy_n1"}, busy, exp_lat > 1);
    wait_valid(lat, res, err);
    chk({name, "_res"}, res, exp_res);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_err"}, err, exp_err);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",  ready,  1'b1);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_valid",  valid,  1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_error",  error,  1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1'b0);
    @(negedge clk);
    run_op("mulh_m1", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 1'b0);
    @(negedge clk);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2, 1'b0);
    @(negedge clk);

    // Second op accepted in the DONE cycle of the first.
    run_op("b2b_first", MUL, 32'd3, 32'd4, 32'd12, 2, 1'b0);
    run_op("b2b_second", MUL, 32'd5, 32'd6, 32'd30, 2, 1'b0);
    @(negedge clk);

    // A request while busy is dropped.
    issue(MUL, 32'd6, 32'd7);
    start = 1'b1; op = MULHU; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    chk("ign_valid", valid, 1'b1);
    chk("ign_res", result, 32'd42);
    @(negedge clk);
    chk("ign_no_second", valid, 1'b0);
    chk("ign_ready", ready, 1'b1);

    // Flush during a multiply: no result, idle next cycle.
    issue(MUL, 32'd7, 32'd8);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_mul_ready", ready, 1'b1);
    chk("flush_mul_valid", valid, 1'b0);
    chk("flush_mul_hold", result, 32'd42);
    @(negedge clk);
    chk("flush_mul_novalid", valid, 1'b0);

    // Start together with flush in IDLE is not accepted.
    start = 1'b1; flush = 1'b1; op = MUL; src_a = 32'd2; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("sf_busy", busy, 1'b0);
    chk("sf_ready", ready, 1'b1);
    @(negedge clk);
    chk("sf_novalid", valid, 1'b0);
    chk("sf_hold", result, 32'd42);

`ifdef MULDIV_DIV_EN
    run_op("div_neg7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
    @(negedge clk);
    run_op("rem_neg7_2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
    @(negedge clk);
    run_op("divu_by0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    @(negedge clk);
    run_op("rem_by0", REM, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    @(negedge clk);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    @(negedge clk);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    @(negedge clk);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2, 34, 1'b0);
    @(negedge clk);

    // Flush in cycle N+10 of a divide.
    issue(DIV, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_div_ready", ready, 1'b1);
    chk("flush_div_busy", busy, 1'b0);
    chk("flush_div_valid", valid, 1'b0);
    repeat (40) @(negedge clk);
    chk("flush_div_hold", result, 32'd2);

    // Reset in the middle of a divide.
    issue(DIVU, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
`else
    run_op("div_noen", DIV, 32'd10, 32'd2, 32'd0, 1, 1'b1);
    @(negedge clk);
    run_op("remu_noen", REMU, 32'd7, 32'd3, 32'd0, 1, 1'b1);
    run_op("mul_after", MUL, 32'd9, 32'd9, 32'd81, 2, 1'b0);
    @(negedge clk);

    // Reset in the middle of a multiply.
    issue(MULHU, 32'd1000, 32'd3);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready",  ready,  1'b1);
    chk("midrst_busy",   busy,   1'b0);
    chk("midrst_valid",  valid,  1'b0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_error",  error,  1'b0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
